ram_stream_reader: RTL
======================

RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 Parameter ADDRL, default 14, is the RAM address width; the RAM depth is 2^ADDRL bytes.
REQ-002 clk  input  1  single clock for all block state; all flops are posedge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle pulse that begins a scan; sampled only in IDLE.
REQ-005 abort  input  1  cancels the current scan; has priority over every other input.
REQ-006 base_addr  input  ADDRL  first RAM address of the scan, sampled on an accepted start.
REQ-007 length  input  ADDRL+1  number of bytes to stream, range 0..2^ADDRL, sampled on an accepted start.
REQ-008 ram_enb  output  1  read enable to the negedge dual-port RAM, port B.
REQ-009 ram_addrb  output  ADDRL  read address to RAM port B.
REQ-010 ram_dob  input  8  RAM read data, valid at the posedge after the issuing cycle.
REQ-011 m_data  output  8  output byte.
REQ-012 m_valid  output  1  m_data is valid.
REQ-013 m_ready  input  1  consumer accepts; a transfer occurs when m_valid and m_ready are both high on a posedge.
REQ-014 busy  output  1  high in RUN and DRAIN.
REQ-015 done  output  1  one-cycle pulse after the last byte of a scan transfers.

Function
REQ-016 The FSM has three states: IDLE, RUN and DRAIN.
  - IDLE->RUN on start when length != 0.
  - RUN->DRAIN when the last read is issued.
  - DRAIN->IDLE when the FIFO is empty and no read is in flight.
REQ-017 A start with length == 0 stays in IDLE, issues no reads, and pulses done on the following cycle.
REQ-018 A start received in RUN or DRAIN is ignored; base_addr and length are not resampled.
REQ-019 Read issue: in RUN, ram_enb=1 with ram_addrb=current address when (FIFO occupancy + reads in flight) < 2; otherwise ram_enb=0.
REQ-020 Read latency:
  - ram_dob is captured into the FIFO exactly one posedge after the issue cycle.
  - At most one read is in flight.
REQ-021 The address increments by 1 per issued read and wraps modulo 2^ADDRL; base=2^ADDRL-1 with length=2 reads addresses 2^ADDRL-1, then 0.
REQ-022 The remaining-count register decrements per issued read; the last read is the one issued with remaining == 1.
REQ-023 The output path is a 2-entry FIFO.
  - m_valid = FIFO not empty; m_data = FIFO head.
  - The FIFO never overflows.
  - Simultaneous push and pop is allowed while non-empty.
REQ-024 Throughput: with m_ready held high, one byte transfers per cycle after a 2-cycle start-up (start cycle, then the first read).
REQ-025 m_data and m_valid stay stable while m_valid=1 and m_ready=0.
REQ-026 Bytes are output in address order with no loss or duplication under arbitrary m_ready patterns.
REQ-027 done pulses on the cycle the FSM enters IDLE from DRAIN.
REQ-028 abort in any state causes the following on the next posedge:
  - FSM goes to IDLE and the FIFO is flushed.
  - Any in-flight read is discarded.
  - m_valid=0, busy=0, and no done pulse.
REQ-029 abort and start in the same cycle: abort wins and no scan starts.
REQ-030 ram_enb=0 in IDLE and DRAIN.

Reset
REQ-031 rst_n low asynchronously forces:
  - state=IDLE, FIFO empty, in-flight flag=0;
  - ram_enb=0, ram_addrb=0, m_valid=0, m_data=0, busy=0, done=0;
  - address and count registers=0.
REQ-032 Reset asserted mid-scan discards all pending data; after release the block is in IDLE and waits for start.

Structure
REQ-033 The shared package ram_stream_pkg holds the FSM state enum and the default ADDRL constant.
REQ-034 The 2-entry FIFO is a sub-module, byte_skid_fifo2, with the same clk/rst_n and push/pop/full/empty ports.
REQ-035 The block is 120-400 lines of RTL; there is no combinational path from m_ready to ram_enb.

Verification
REQ-036 Continuous drain: RAM preloaded with ram[i]=i[7:0], base=0x10, length=4, m_ready=1 -> m_data 0x10,0x11,0x12,0x13 on consecutive cycles, then done pulses once.
REQ-037 Wrap-around: base=0x3FFE (ADDRL=14), length=3 -> reads 0x3FFE,0x3FFF,0x0000 in that order.
REQ-038 Backpressure: length=8, m_ready toggling 1,0,0,1,... -> all 8 bytes in order with none lost or duplicated, and ram_enb=0 whenever FIFO occupancy plus in-flight reads equals 2.
REQ-039 Zero length: start with length=0 -> ram_enb is never asserted, done pulses 1 cycle later, busy stays 0.
REQ-040 Abort: abort asserted on the 3rd byte of length=10 -> next cycle m_valid=0, busy=0, no done; a new start then streams correctly from its base_addr.
REQ-041 Reset mid-scan: rst_n pulsed low during RUN -> all outputs take their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ram_stream_pkg.sv
// Shared definitions for the RAM stream reader: FSM state encoding and the
// default RAM address width.
package ram_stream_pkg;

  localparam int unsigned ADDRL_DEFAULT = 14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/byte_skid_fifo2.sv
// Two-entry byte FIFO used as the output skid buffer of the stream reader.
// The head entry is presented combinationally on dout. A push and a pop in
// the same cycle are allowed. The flush input empties the FIFO without
// touching the storage, so dout can still show a stale byte after a flush.
module byte_skid_fifo2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty,
  output logic [1:0] count
);

  logic [7:0] r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;

  logic       w_push;
  logic       w_pop;

  // Pops are ignored when empty. Pushes are ignored when full, unless a pop
  // in the same cycle frees a slot.
  assign w_pop  = pop && (r_count != 2'd0);
  assign w_push = push && ((r_count != 2'd2) || w_pop);

  // Storage, pointers and occupancy; flush resets the pointers only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = (r_count == 2'd2);
  assign empty = (r_count == 2'd0);
  assign count = r_count;

endmodule

// File: rtl/ram_stream_reader.sv
// Streams `length` bytes from a negedge-clocked dual-port RAM (port B),
// starting at base_addr, onto a valid/ready byte stream. The address wraps
// modulo 2^ADDRL. A 2-entry FIFO absorbs consumer backpressure.
module ram_stream_reader #(
  parameter int unsigned ADDRL = ram_stream_pkg::ADDRL_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [ADDRL-1:0] base_addr,
  input  logic [ADDRL:0]   length,
  output logic             ram_enb,
  output logic [ADDRL-1:0] ram_addrb,
  input  logic [7:0]       ram_dob,
  output logic [7:0]       m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             busy,
  output logic             done
);

  import ram_stream_pkg::*;

  localparam int unsigned LW = ADDRL + 1;

  state_t           r_state;
  logic [ADDRL-1:0] r_addr;
  logic [ADDRL:0]   r_rem;
  logic             r_done;

  logic             w_full;
  logic             w_empty;
  logic [1:0]       w_count;
  logic             w_issue;
  logic             w_pop;
  logic             w_drained;

  // The RAM latches the read on the negedge inside the issue cycle, and the
  // data is captured into the FIFO at the posedge that closes that cycle.
  // Because of this, the in-flight read is always the one being issued now,
  // and gating on FIFO fullness is the same as gating on occupancy plus
  // reads in flight. The gate depends only on registered state, so
  // m_ready never reaches ram_enb combinationally.
  assign w_issue = (r_state == ST_RUN) && !w_full;
  assign w_pop   = !w_empty && m_ready;

  // True when the FIFO will be empty after this edge. Nothing is pushed
  // while in DRAIN.
  assign w_drained = w_empty || ((w_count == 2'd1) && w_pop);

  byte_skid_fifo2 u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (abort),
    .push  (w_issue),
    .din   (ram_dob),
    .pop   (w_pop),
    .dout  (m_data),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // Scan control FSM: address and remaining count, state, and the done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_rem   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              if (length == '0) begin
                r_done <= 1'b1;
              end else begin
                r_state <= ST_RUN;
                r_addr  <= base_addr;
                r_rem   <= length;
              end
            end
          end
          ST_RUN: begin
            if (w_issue) begin
              r_addr <= r_addr + ADDRL'(1);
              r_rem  <= r_rem - LW'(1);
              if (r_rem == LW'(1)) begin
                r_state <= ST_DRAIN;
              end
            end
          end
          ST_DRAIN: begin
            if (w_drained) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign ram_enb   = w_issue;
  assign ram_addrb = r_addr;
  assign m_valid   = !w_empty;
  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;

endmodule
